// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path and the planned transmit path.
// Contents: the frame-level state encoding and the default frame geometry.
package uart_pkg;

    localparam int UART_OS_RATE = 16;  // oversample ticks per bit
    localparam int UART_DBIT    = 8;   // data bits per frame

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and oversample strobe in,
// parallel word, done strobe, error flags and busy out.
//   master : the receiver (consumes rx/s_tick, drives the results)
//   slave  : the line/baud source plus the downstream consumer
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DBIT = UART_DBIT
);
    logic            rx;            // serial line, asynchronous, idle high
    logic            s_tick;        // oversample strobe, one clk wide
    logic [DBIT-1:0] dout;          // last received word
    logic            rx_done_tick;  // one-cycle pulse when results update
    logic            frame_err;     // stop bit sampled low on last frame
    logic            parity_err;    // parity mismatch on last frame
    logic            busy;          // receiver not idle

    modport master (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err, busy
    );

    modport slave (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk     : destination clock
//   reset   : asynchronous, active-low; both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronised output, two clk of latency
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x (OS_RATE) oversampling, mid-bit sampling,
// optional parity and configurable stop length.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : uart_rx_if.master -- rx, s_tick in; dout, rx_done_tick,
//           frame_err, parity_err, busy out
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = UART_DBIT,
    parameter int SB_TICK    = 16,
    parameter int OS_RATE    = UART_OS_RATE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(OS_RATE + SB_TICK);
    localparam int NW = $clog2(DBIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OS_RATE - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic          PAR       = (PARITY_EN != 0);
    localparam logic          ODD       = (PARITY_ODD != 0);

    logic rx_s;

    uart_state_e     state, state_n;
    logic [CW-1:0]   s_cnt, s_cnt_n;
    logic [NW-1:0]   n_cnt, n_cnt_n;
    logic [DBIT-1:0] sr, sr_n;
    logic            p_bad, p_bad_n;
    logic [DBIT-1:0] dout_q, dout_n;
    logic            done_q, done_n;
    logic            ferr_q, ferr_n;
    logic            perr_q, perr_n;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            sr     <= '0;
            p_bad  <= 1'b0;
            dout_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_n;
            s_cnt  <= s_cnt_n;
            n_cnt  <= n_cnt_n;
            sr     <= sr_n;
            p_bad  <= p_bad_n;
            dout_q <= dout_n;
            done_q <= done_n;
            ferr_q <= ferr_n;
            perr_q <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        sr_n    = sr;
        p_bad_n = p_bad;
        dout_n  = dout_q;
        done_n  = 1'b0;
        ferr_n  = ferr_q;
        perr_n  = perr_q;

        unique case (state)
            IDLE: begin
                // Start-bit edge detection runs at clk rate, not tick rate.
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_cnt == HALF_LAST) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = IDLE;  // glitch: nothing reported
                        end
                    end else begin
                        s_cnt_n = s_cnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_cnt_n = '0;
                        sr_n    = {rx_s, sr[DBIT-1:1]};
                        if (n_cnt == N_LAST) begin
                            state_n = PAR ? PARITY : STOP;
                        end else begin
                            n_cnt_n = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        p_bad_n = (^sr) ^ rx_s ^ ODD;
                        s_cnt_n = '0;
                        state_n = STOP;
                    end else begin
                        s_cnt_n = s_cnt + CW'(1);
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_cnt == STOP_LAST) begin
                        // Stop bit is judged at the final tick, so long stop
                        // settings check the line at the end of the stop period.
                        state_n = IDLE;
                        done_n  = 1'b1;
                        dout_n  = sr;
                        ferr_n  = ~rx_s;
                        perr_n  = PAR & p_bad;
                    end else begin
                        s_cnt_n = s_cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
    assign bus.parity_err   = perr_q;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if #(.DBIT(8)) bus0 ();
    uart_rx_if #(.DBIT(8)) bus1 ();

    uart_rx #(.DBIT(8), .SB_TICK(16), .OS_RATE(16), .PARITY_EN(0), .PARITY_ODD(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    uart_rx #(.DBIT(8), .SB_TICK(16), .OS_RATE(16), .PARITY_EN(1), .PARITY_ODD(0))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // s_tick every 4 clk, changed 2 time units after the rising edge.
    int tdiv = 0;
    always @(posedge clk) begin
        #2;
        tdiv = (tdiv + 1) % 4;
        bus0.s_tick = (tdiv == 0);
        bus1.s_tick = (tdiv == 0);
    end

    typedef struct {
        logic [7:0] dout;
        logic       ferr;
        logic       perr;
        logic       busy_after;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    bit  pend0 = 0;
    bit  pend1 = 0;

    // Record every done pulse and the busy level one cycle later.
    always @(negedge clk) begin
        ev_t e;
        if (pend0) begin
            e = q0.pop_back();
            e.busy_after = bus0.busy;
            q0.push_back(e);
            pend0 = 0;
        end
        if (pend1) begin
            e = q1.pop_back();
            e.busy_after = bus1.busy;
            q1.push_back(e);
            pend1 = 0;
        end
        if (bus0.rx_done_tick === 1'b1) begin
            e = '{bus0.dout, bus0.frame_err, bus0.parity_err, 1'bx};
            q0.push_back(e);
            pend0 = 1;
        end
        if (bus1.rx_done_tick === 1'b1) begin
            e = '{bus1.dout, bus1.frame_err, bus1.parity_err, 1'bx};
            q1.push_back(e);
            pend1 = 1;
        end
    end

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) bus0.rx = v;
        else          bus1.rx = v;
    endtask

    // Bit period is 64 clk. A low stop bit is held for only 48 clk so the
    // receiver's immediate restart sees a high line at its half-bit check.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_ok);
        set_rx(sel, 1'b0);
        wait_clks(64);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            wait_clks(64);
        end
        if (has_par) begin
            set_rx(sel, par_bit);
            wait_clks(64);
        end
        if (stop_ok) begin
            set_rx(sel, 1'b1);
            wait_clks(64);
        end else begin
            set_rx(sel, 1'b0);
            wait_clks(48);
            set_rx(sel, 1'b1);
            wait_clks(16);
        end
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       has_par;
        logic       par_bit;
        logic       stop_ok;
        int         gap;
        logic [7:0] exp_dout;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_busy;
    } vec_t;

    task automatic pop_check(input int sel, input string tag, input logic [7:0] edout,
                             input logic eferr, input logic eperr, input logic ebusy);
        ev_t e;
        int  n;
        n = (sel == 0) ? q0.size() : q1.size();
        check({tag, "_pulses"}, n, 1);
        if (n >= 1) begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            check({tag, "_dout"}, e.dout, edout);
            check({tag, "_ferr"}, e.ferr, eferr);
            check({tag, "_perr"}, e.perr, eperr);
            check({tag, "_busy_after"}, e.busy_after, ebusy);
        end
        if (sel == 0) q0.delete();
        else          q1.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        send_frame(v.sel, v.data, v.has_par, v.par_bit, v.stop_ok);
        wait_clks(v.gap);
        pop_check(v.sel, tag, v.exp_dout, v.exp_ferr, v.exp_perr, v.exp_busy);
    endtask

    vec_t vecs[10];
    vec_t v;
    ev_t  e;

    initial begin
        vecs[0] = '{0, 8'h55, 0, 0, 1, 64,  8'h55, 0, 0, 0};
        vecs[1] = '{0, 8'hA3, 0, 0, 1, 0,   8'hA3, 0, 0, 0};  // back-to-back
        vecs[2] = '{0, 8'h0F, 0, 0, 1, 64,  8'h0F, 0, 0, 0};
        vecs[3] = '{0, 8'h3C, 0, 0, 0, 128, 8'h3C, 1, 0, 1};  // stop low
        vecs[4] = '{0, 8'h81, 0, 0, 1, 64,  8'h81, 0, 0, 0};
        vecs[5] = '{1, 8'h07, 1, 1, 1, 64,  8'h07, 0, 0, 0};  // even parity ok
        vecs[6] = '{1, 8'h07, 1, 0, 1, 64,  8'h07, 0, 1, 0};  // parity bad
        vecs[7] = '{1, 8'h00, 1, 0, 1, 64,  8'h00, 0, 0, 0};
        vecs[8] = '{0, 8'h00, 0, 0, 1, 64,  8'h00, 0, 0, 0};
        vecs[9] = '{0, 8'hFF, 0, 0, 1, 64,  8'hFF, 0, 0, 0};

        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        bus0.s_tick = 1'b0;
        bus1.s_tick = 1'b0;
        reset = 1'b0;
        wait_clks(5);
        check("rst_dout", bus0.dout, 0);
        check("rst_done", bus0.rx_done_tick, 0);
        check("rst_ferr", bus0.frame_err, 0);
        check("rst_perr", bus0.parity_err, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_busy_par", bus1.busy, 0);
        reset = 1'b1;
        wait_clks(20);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            run_vec(v, $sformatf("vec%0d", i));
        end

        // Short low pulse: start rejected, nothing reported, dout keeps 0xFF.
        bus0.rx = 1'b0;
        wait_clks(20);
        bus0.rx = 1'b1;
        wait_clks(100);
        check("glitch_pulses", q0.size(), 0);
        check("glitch_busy", bus0.busy, 0);
        check("glitch_dout", bus0.dout, 8'hFF);
        check("glitch_ferr", bus0.frame_err, 0);

        // Break: two back-to-back framing errors, then recovery.
        bus0.rx = 1'b0;
        wait_clks(1240);
        bus0.rx = 1'b1;
        wait_clks(200);
        check("break_pulses", q0.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("break_dout", e.dout, 8'h00);
                check("break_ferr", e.ferr, 1);
                check("break_busy_after", e.busy_after, 1);
            end
        end
        q0.delete();
        check("break_idle", bus0.busy, 0);
        send_frame(0, 8'h5A, 0, 0, 1);
        wait_clks(64);
        pop_check(0, "after_break", 8'h5A, 0, 0, 0);

        // Reset in the middle of the data bits of 0xFF.
        bus0.rx = 1'b0;
        wait_clks(64);
        bus0.rx = 1'b1;
        wait_clks(192);
        check("mid_busy_pre", bus0.busy, 1);
        reset = 1'b0;
        wait_clks(1);
        check("mid_rst_dout", bus0.dout, 0);
        check("mid_rst_done", bus0.rx_done_tick, 0);
        check("mid_rst_ferr", bus0.frame_err, 0);
        check("mid_rst_perr", bus0.parity_err, 0);
        check("mid_rst_busy", bus0.busy, 0);
        wait_clks(4);
        reset = 1'b1;
        wait_clks(600);
        check("mid_no_pulse", q0.size(), 0);
        check("mid_idle", bus0.busy, 0);
        q0.delete();
        send_frame(0, 8'h12, 0, 0, 1);
        wait_clks(64);
        pop_check(0, "post_rst", 8'h12, 0, 0, 0);

        check("par_spurious", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule
